// File: rtl/press_pkg.sv
// Shared constants for the press sequencer: FSM state encodings and tick counter sizing.
// Pure definitions; no logic, no latency, no flow control.
package press_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESSED   = 2'd1;
  localparam logic [1:0] LONG_HELD = 2'd2;

  localparam int TICKS_W = 4;
  localparam logic [TICKS_W-1:0] TICKS_MAX = 4'd15;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; tick is asserted
// combinationally in the last count of the period. No backpressure; clear overrides enable.
module tick_prescaler #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/press_sequencer.sv
// Times debounced presses, classifies short/long, drives a wrapping press counter and strobes.
// All outputs registered, one cycle after the sampled event; no backpressure (events are pulses).
module press_sequencer
  import press_pkg::*;
#(
  parameter int TICK_DIV   = 12_500_000,
  parameter int LONG_TICKS = 12,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pb_down,
  input  logic               pb_up,
  input  logic               pb_state,
  output logic [CNT_W-1:0]   count,
  output logic [TICKS_W-1:0] ticks,
  output logic               short_pulse,
  output logic               long_pulse,
  output logic               press_active
);

  localparam logic [TICKS_W-1:0] LONG_M1 = TICKS_W'(LONG_TICKS - 1);

  logic [1:0] state;
  logic [1:0] nstate;
  logic       rel_q;
  logic       release_ev;
  logic       start;
  logic       short_ev;
  logic       long_ev;
  logic       tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (state != IDLE),
    .tick   (tick)
  );

  // A released level seen on two consecutive cycles stands in for a lost pb_up.
  assign release_ev = pb_up || (pb_state && rel_q);

  always_comb begin
    nstate   = state;
    start    = 1'b0;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    case (state)
      IDLE: begin
        if (pb_down) begin
          nstate = PRESSED;
          start  = 1'b1;
        end
      end
      PRESSED: begin
        if (tick && (ticks == LONG_M1)) begin
          long_ev = 1'b1;
          nstate  = release_ev ? IDLE : LONG_HELD;
        end else if (release_ev) begin
          short_ev = 1'b1;
          nstate   = IDLE;
        end
      end
      LONG_HELD: begin
        if (release_ev) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rel_q        <= 1'b0;
      ticks        <= '0;
      count        <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      press_active <= 1'b0;
    end else begin
      state        <= nstate;
      rel_q        <= (state != IDLE) && pb_state;
      short_pulse  <= short_ev;
      long_pulse   <= long_ev;
      press_active <= (nstate != IDLE);
      if (start) begin
        ticks <= '0;
      end else if (tick && (ticks != TICKS_MAX)) begin
        ticks <= ticks + 1'b1;
      end
      if (long_ev) begin
        count <= '0;
      end else if (short_ev) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_press_sequencer.sv
// Directed bench for press_sequencer with TICK_DIV=4, LONG_TICKS=12, CNT_W=3.
module tb_press_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pb_down;
  logic       pb_up;
  logic       pb_state;
  logic [2:0] count;
  logic [3:0] ticks;
  logic       short_pulse;
  logic       long_pulse;
  logic       press_active;

  int checks = 0;
  int errors = 0;

  press_sequencer #(.TICK_DIV(4), .LONG_TICKS(12), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_down      (pb_down),
    .pb_up        (pb_up),
    .pb_state     (pb_state),
    .count        (count),
    .ticks        (ticks),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .press_active (press_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       down;
    logic       up;
    logic       lvl;
    logic [2:0] cnt;
    logic [3:0] tk;
    logic       sp;
    logic       lp;
    logic       act;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic [3:0] t,
                         input logic sp, input logic lp, input logic act);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".ticks"}, 32'(ticks), 32'(t));
    chk({tag, ".short"}, 32'(short_pulse), 32'(sp));
    chk({tag, ".long"}, 32'(long_pulse), 32'(lp));
    chk({tag, ".active"}, 32'(press_active), 32'(act));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pb_down = 1'b0;
    pb_up = 1'b0;
    pb_state = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Press, then sample pb_up on the n-th edge after the pb_down edge; pb_up left high.
  task automatic press_for(input int n);
    pb_down = 1'b1;
    pb_state = 1'b0;
    step();
    pb_down = 1'b0;
    repeat (n - 1) step();
    pb_up = 1'b1;
    pb_state = 1'b1;
    step();
  endtask

  initial begin
    // down up lvl | count ticks short long active
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'd1, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    pb_down = 1'b0;
    pb_up = 1'b0;
    pb_state = 1'b1;
    #2;
    chk_all("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      pb_down = tbl[i].down;
      pb_up = tbl[i].up;
      pb_state = tbl[i].lvl;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].tk, tbl[i].sp, tbl[i].lp, tbl[i].act);
    end
    pb_up = 1'b0;
    pb_down = 1'b0;

    // Missed release: level high for two cycles, no pb_up.
    pb_down = 1'b1;
    pb_state = 1'b0;
    step();
    pb_down = 1'b0;
    pb_state = 1'b1;
    step();
    chk_all("missed1", 3'd2, 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("missed2", 3'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    step();

    // Release sampled 47 cycles after pb_down: still short.
    press_for(47);
    chk_all("rel47", 3'd4, 4'd11, 1'b1, 1'b0, 1'b0);
    pb_up = 1'b0;
    step();

    // Release coincident with tick 12: long only, back to IDLE.
    press_for(48);
    chk_all("rel48", 3'd0, 4'd12, 1'b0, 1'b1, 1'b0);
    pb_up = 1'b0;
    pb_down = 1'b1;
    pb_state = 1'b0;
    step();
    chk_all("b2b_down", 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    pb_down = 1'b0;
    pb_up = 1'b1;
    pb_state = 1'b1;
    step();
    chk_all("b2b_up", 3'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    pb_up = 1'b0;
    step();

    // Long press held past saturation.
    pb_down = 1'b1;
    pb_state = 1'b0;
    step();
    pb_down = 1'b0;
    for (int n = 1; n < 68; n++) begin
      step();
      chk($sformatf("long_t%0d.ticks", n), 32'(ticks), (n / 4 > 15) ? 32'd15 : 32'(n / 4));
      chk($sformatf("long_t%0d.long", n), 32'(long_pulse), (n == 48) ? 32'd1 : 32'd0);
      chk($sformatf("long_t%0d.short", n), 32'(short_pulse), 32'd0);
      if (n == 47) chk("long_pre.count", 32'(count), 32'd1);
      if (n == 48) chk("long_clr.count", 32'(count), 32'd0);
    end
    pb_up = 1'b1;
    pb_state = 1'b1;
    step();
    chk_all("long_rel", 3'd0, 4'd15, 1'b0, 1'b0, 1'b0);
    pb_up = 1'b0;
    step();

    // Wrap-around of the press counter.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press_for(2);
      chk_all($sformatf("wrap%0d", i), 3'((i + 1) % 8), 4'd0, 1'b1, 1'b0, 1'b0);
      pb_up = 1'b0;
      step();
    end

    // Asynchronous reset mid-press with count=5.
    for (int i = 0; i < 5; i++) begin
      press_for(2);
      pb_up = 1'b0;
      step();
    end
    chk("pre_rst.count", 32'(count), 32'd5);
    pb_down = 1'b1;
    pb_state = 1'b0;
    step();
    pb_down = 1'b0;
    repeat (24) step();
    chk("pre_rst.ticks", 32'(ticks), 32'd6);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    pb_up = 1'b1;
    pb_state = 1'b1;
    step();
    chk_all("post_rst_up", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    pb_up = 1'b0;
    step();
    chk_all("post_rst_idle", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
